alp_opnd_latch: RTL
===================

Name: alp_opnd_latch

Overview:
- Operand capture stage directly downstream of the ALP mux decoder.
- Consumes the decoded A-mux one-hot (R, M, D, P) and B-mux one-hot (R, Q, S) selects, gates the matching source buses, and registers the A and B operands for the ALU slice on the next cycle.
- Owns the D and Q holding registers that feed the D->A and Q->B paths.
- Supports a pipeline hold from the microsequencer.

Parameters:
WIDTH, 8, data path width of one ALP slice in bits

Ports:
clk_h  in  1  system clock, rising edge
reset_l  in  1  asynchronous active-low reset
stall_h  in  1  hold; freezes every register in the block
ld_ena_h  in  1  capture request for A/B operands this cycle
amux_onehot_h  in  4  {rbus, mbus, dreg, pad} A select from decoder
bmux_onehot_h  in  3  {rbus, qreg, smux} B select from decoder
rbus_h  in  WIDTH  register-file bus
mbus_h  in  WIDTH  memory bus
pad_h  in  WIDTH  pad (external) bus
smux_h  in  WIDTH  shifter output
dreg_wr_h  in  1  load D register
dreg_d_h  in  WIDTH  D register write data
qreg_wr_h  in  1  load Q register
qreg_d_h  in  WIDTH  Q register write data
err_clr_h  in  1  clear sticky select error
a_h  out  WIDTH  registered A operand
b_h  out  WIDTH  registered B operand
dreg_h  out  WIDTH  current D register
qreg_h  out  WIDTH  current Q register
opnd_vld_h  out  1  a_h/b_h hold freshly captured operands
sel_err_h  out  1  sticky one-hot violation flag

Behaviour:
- Reset: the interface uses one clock, clk_h; reset_l is asynchronous and active-low. While reset_l is low, a_h, b_h, dreg_h, qreg_h = 0, and opnd_vld_h, sel_err_h = 0. Reset takes effect immediately, including mid-capture or mid-stall. The first capture after release behaves normally.
- Operand select (combinational, before the registers):
  - A = OR over i of (amux_onehot_h[i] ? source_i : 0), using sources rbus_h, mbus_h, dreg_h, pad_h. This is wired-OR semantics.
  - B is formed the same way from rbus_h, qreg_h, smux_h.
  - An all-zero select yields 0. Multiple set bits yield the bitwise OR of the selected sources.
- Capture: on a rising edge with stall_h=0 and ld_ena_h=1, a_h<=A and b_h<=B, and opnd_vld_h<=1. Latency is 1 cycle.
- Idle: on an edge with stall_h=0 and ld_ena_h=0, a_h and b_h hold and opnd_vld_h<=0.
- Stall: while stall_h=1, all registers hold, including opnd_vld_h, D, Q and sel_err_h. ld_ena_h, dreg_wr_h and qreg_wr_h are ignored. err_clr_h is still honoured.
- D register: on an edge with stall_h=0 and dreg_wr_h=1, dreg_h<=dreg_d_h. Q register follows the same rule with qreg_wr_h and qreg_d_h.
- Same-cycle write and select: if D (or Q) is written and selected in the same capture cycle, the operand takes the OLD register value. The new value is visible from the next cycle.
- Error flag (only when the optional feature is present):
  - Set on an accepted capture if popcount(amux_onehot_h) != 1 or popcount(bmux_onehot_h) != 1.
  - Sticky until err_clr_h=1 at an edge.
  - If set and clear occur in the same edge, set wins.

Optional Feature:
- Macro: ALP_ONEHOT_CHECK_EN.
- When defined: sel_err_h is implemented as specified under Error flag.
- When undefined: sel_err_h is tied to 0, err_clr_h is unused, and no popcount logic is generated. Operand behaviour is identical in both builds.

Test Plan:
- Reset check: hold reset_l=0 with all inputs toggling -> all outputs 0. Release, then capture with amux=0100 (M), mbus_h=0x5A -> a_h=0x5A one cycle later, opnd_vld_h=1.
- D path with write/select collision: write dreg_d_h=0x3C, then the next cycle capture amux=0010 while also writing dreg_d_h=0xFF -> a_h=0x3C and dreg_h=0xFF. A following D capture -> a_h=0xFF.
- B select sweep: bmux=100/010/001 with rbus=0x11, qreg=0x22, smux=0x44 -> b_h=0x11, 0x22, 0x44 on successive cycles.
- Stall mid-sequence: capture, then stall_h=1 for 3 cycles with ld_ena_h=1 and changing buses -> a_h, b_h and opnd_vld_h=1 frozen. Drop stall with ld_ena_h=0 -> opnd_vld_h=0.
- Illegal selects (ALP_ONEHOT_CHECK_EN defined): capture with amux=1100, rbus=0x0F, mbus=0xF0 -> a_h=0xFF and sel_err_h=1 stays set. Then assert err_clr_h together with a bmux=000 capture -> sel_err_h remains 1 (set wins). A clean clear -> 0.
- Asynchronous reset during a stall: pulse reset_l low between clock edges -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alp_opnd_latch.sv
// ---------------------------------------------------------------------------
// alp_opnd_latch -- operand capture stage behind the ALP mux decoder.
//
// Gates the source buses with the decoded A/B one-hot selects and registers
// the A and B operands for the ALU slice. It also owns the D and Q holding
// registers that feed the D->A and Q->B paths. stall_h freezes every
// register; only err_clr_h is still honoured during a stall.
//
// Optional feature (macro ALP_ONEHOT_CHECK_EN):
//   defined   -> sel_err_h is a sticky flag. It sets on an accepted capture
//                whose A or B select is not exactly one-hot, and clears on
//                err_clr_h. If set and clear occur on the same edge, set wins.
//   undefined -> sel_err_h is tied low and err_clr_h is unused.
//
// Ports:
//   clk_h          in   system clock, rising edge
//   reset_l        in   asynchronous active-low reset
//   stall_h        in   pipeline hold from the microsequencer
//   ld_ena_h       in   capture A/B operands this cycle
//   amux_onehot_h  in   [3:0] {rbus, mbus, dreg, pad} A select
//   bmux_onehot_h  in   [2:0] {rbus, qreg, smux} B select
//   rbus_h         in   register-file bus
//   mbus_h         in   memory bus
//   pad_h          in   pad (external) bus
//   smux_h         in   shifter output
//   dreg_wr_h      in   load D register
//   dreg_d_h       in   D register write data
//   qreg_wr_h      in   load Q register
//   qreg_d_h       in   Q register write data
//   err_clr_h      in   clear the sticky select error
//   a_h            out  registered A operand
//   b_h            out  registered B operand
//   dreg_h         out  current D register
//   qreg_h         out  current Q register
//   opnd_vld_h     out  a_h/b_h hold freshly captured operands
//   sel_err_h      out  sticky one-hot violation flag
// ---------------------------------------------------------------------------
module alp_opnd_latch #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             stall_h,
    input  logic             ld_ena_h,
    input  logic [3:0]       amux_onehot_h,
    input  logic [2:0]       bmux_onehot_h,
    input  logic [WIDTH-1:0] rbus_h,
    input  logic [WIDTH-1:0] mbus_h,
    input  logic [WIDTH-1:0] pad_h,
    input  logic [WIDTH-1:0] smux_h,
    input  logic             dreg_wr_h,
    input  logic [WIDTH-1:0] dreg_d_h,
    input  logic             qreg_wr_h,
    input  logic [WIDTH-1:0] qreg_d_h,
    input  logic             err_clr_h,
    output logic [WIDTH-1:0] a_h,
    output logic [WIDTH-1:0] b_h,
    output logic [WIDTH-1:0] dreg_h,
    output logic [WIDTH-1:0] qreg_h,
    output logic             opnd_vld_h,
    output logic             sel_err_h
);

    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] b_sel_c;
    logic             capture_c;

    // Wired-OR operand select. An all-zero select gives 0, and several set
    // bits OR their sources together. The D and Q terms read the register
    // outputs, so a same-cycle write is seen only from the next capture.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        a_sel_c = ({WIDTH{amux_onehot_h[3]}} & rbus_h)
                | ({WIDTH{amux_onehot_h[2]}} & mbus_h)
                | ({WIDTH{amux_onehot_h[1]}} & dreg_h)
                | ({WIDTH{amux_onehot_h[0]}} & pad_h);
        b_sel_c = ({WIDTH{bmux_onehot_h[2]}} & rbus_h)
                | ({WIDTH{bmux_onehot_h[1]}} & qreg_h)
                | ({WIDTH{bmux_onehot_h[0]}} & smux_h);
    end

    assign capture_c = ~stall_h & ld_ena_h;

    // Operand registers and the freshness flag.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            a_h        <= '0;
            b_h        <= '0;
            opnd_vld_h <= 1'b0;
        end else if (!stall_h) begin
            if (ld_ena_h) begin
                a_h        <= a_sel_c;
                b_h        <= b_sel_c;
                opnd_vld_h <= 1'b1;
            end else begin
                opnd_vld_h <= 1'b0;
            end
        end
    end

    // D and Q holding registers.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            dreg_h <= '0;
            qreg_h <= '0;
        end else if (!stall_h) begin
            if (dreg_wr_h) begin
                dreg_h <= dreg_d_h;
            end
            if (qreg_wr_h) begin
                qreg_h <= qreg_d_h;
            end
        end
    end

`ifdef ALP_ONEHOT_CHECK_EN
    logic sel_bad_c;

    assign sel_bad_c = ($countones(amux_onehot_h) != 32'(1))
                     | ($countones(bmux_onehot_h) != 32'(1));

    // Sticky select error. Clear works even under stall; a set on the same
    // edge wins over the clear.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            sel_err_h <= 1'b0;
        end else if (capture_c && sel_bad_c) begin
            sel_err_h <= 1'b1;
        end else if (err_clr_h) begin
            sel_err_h <= 1'b0;
        end
    end
`else
    logic err_clr_unused;
    logic capture_unused;

    assign err_clr_unused = err_clr_h;
    assign capture_unused = capture_c;
    assign sel_err_h      = 1'b0;
`endif

endmodule
